// File: rtl/interrupt_controller_pkg.sv
// ---------------------------------------------------------------------------
// interrupt_controller_pkg
//
// Shared definitions for the interrupt controller and its neighbours on the
// IO bus:
//   - IF / IE register addresses on the memory-mapped IO bus
//   - interrupt source index constants (bit positions in IF / IE)
//   - dispatch vector constants for each source
//   - default parameter values for the controller
//   - FSM state encoding and a vector-address helper
// ---------------------------------------------------------------------------
package interrupt_controller_pkg;

  // IO register addresses
  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  // Source indices; a lower index means a higher priority
  localparam int INT_VBLANK = 0;
  localparam int INT_STAT   = 1;
  localparam int INT_TIMER  = 2;
  localparam int INT_SERIAL = 3;
  localparam int INT_JOYPAD = 4;

  // Dispatch vectors for each source
  localparam logic [15:0] VEC_VBLANK = 16'h0040;
  localparam logic [15:0] VEC_STAT   = 16'h0048;
  localparam logic [15:0] VEC_TIMER  = 16'h0050;
  localparam logic [15:0] VEC_SERIAL = 16'h0058;
  localparam logic [15:0] VEC_JOYPAD = 16'h0060;

  // Default configuration of the controller
  localparam int          NUM_SRC_DEFAULT       = 5;
  localparam logic [15:0] VECTOR_BASE_DEFAULT   = 16'h0040;
  localparam int          VECTOR_STRIDE_DEFAULT = 8;

  // Dispatch handshake states
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } intc_state_e;

  // Dispatch address of the source at index idx
  function automatic logic [15:0] int_vector(input logic [15:0] base,
                                             input int          stride,
                                             input int          idx);
    return base + 16'(stride * idx);
  endfunction

endpackage

// File: rtl/int_priority_enc.sv
// ---------------------------------------------------------------------------
// int_priority_enc
//
// Combinational lowest-set-bit encoder used to pick the highest-priority
// pending interrupt.
//
// Parameters:
//   WIDTH  number of request bits
//   IDX_W  width of the index output
// Ports:
//   I_REQ    in   WIDTH  request vector (bit 0 = highest priority)
//   O_VALID  out  1      at least one request bit is set
//   O_IDX    out  IDX_W  index of the lowest set bit (0 when none set)
// ---------------------------------------------------------------------------
module int_priority_enc #(
  parameter int WIDTH = 5,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] I_REQ,
  output logic             O_VALID,
  output logic [IDX_W-1:0] O_IDX
);

  // Scanning from the top down lets the lowest set bit overwrite any higher one
  always_comb begin
    O_VALID = |I_REQ;
    O_IDX   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (I_REQ[i]) begin
        O_IDX = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Collects single-cycle and level interrupt requests into IF (0xFF0F), masks
// them with IE (0xFFFF) and presents a prioritised pending flag plus dispatch
// vector to the CPU. A level acknowledge from the CPU latches the vector and
// clears the serviced IF bit.
//
// Configuration macro:
//   INTC_WAKE_EN  when defined, adds the registered O_WAKE output used to
//                 release HALT/STOP independent of IME.
//
// Ports:
//   I_CLOCK        in     1        system clock
//   I_RESET        in     1        asynchronous active-high reset
//   I_ADDR         in     16       bus address
//   IO_DATA        inout  8        bus data, driven only while IF/IE is read
//   I_RE_L         in     1        bus read enable, active-low
//   I_WE_L         in     1        bus write enable, active-low
//   I_INT_SRC      in     NUM_SRC  request lines (0 VBlank .. 4 Joypad)
//   I_INT_ACK      in     1        CPU dispatch acknowledge (level)
//   O_INT_PENDING  out    1        any enabled request pending
//   O_INT_VECTOR   out    16       dispatch address
//   O_IF_DATA      out    8        IF as seen by a bus read
//   O_IE_DATA      out    8        IE contents
//   O_WAKE         out    1        (INTC_WAKE_EN only) registered wake request
// ---------------------------------------------------------------------------
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_SRC       = NUM_SRC_DEFAULT,
  parameter logic [15:0] VECTOR_BASE   = VECTOR_BASE_DEFAULT,
  parameter int          VECTOR_STRIDE = VECTOR_STRIDE_DEFAULT
) (
  input  logic               I_CLOCK,
  input  logic               I_RESET,
  input  logic [15:0]        I_ADDR,
  inout  wire  [7:0]         IO_DATA,
  input  logic               I_RE_L,
  input  logic               I_WE_L,
  input  logic [NUM_SRC-1:0] I_INT_SRC,
  input  logic               I_INT_ACK,
  output logic               O_INT_PENDING,
  output logic [15:0]        O_INT_VECTOR,
  output logic [7:0]         O_IF_DATA,
  output logic [7:0]         O_IE_DATA
`ifdef INTC_WAKE_EN
  ,
  output logic               O_WAKE
`endif
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] if_q, if_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [7:0]         ie_q, ie_d;
  intc_state_e        state_q, state_d;
  logic [15:0]        vec_latch_q, vec_latch_d;

  logic [NUM_SRC-1:0] set_bits;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] pend;
  logic               pend_valid;
  logic [IDX_W-1:0]   pend_idx;
  logic [15:0]        live_vec;

  logic               if_rd, ie_rd, if_we, ie_we;
  logic [7:0]         if_rd_data;

  // Bus decode
  assign if_rd = ~I_RE_L & (I_ADDR == ADDR_IF);
  assign ie_rd = ~I_RE_L & (I_ADDR == ADDR_IE);
  assign if_we = ~I_WE_L & (I_ADDR == ADDR_IF);
  assign ie_we = ~I_WE_L & (I_ADDR == ADDR_IE);

  // Unimplemented IF bits read back as 1
  always_comb begin
    if_rd_data              = 8'hFF;
    if_rd_data[NUM_SRC-1:0] = if_q;
  end

  assign IO_DATA = if_rd ? if_rd_data :
                   ie_rd ? ie_q       : 8'hzz;

  assign pend = if_q & ie_q[NUM_SRC-1:0];

  int_priority_enc #(
    .WIDTH (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .I_REQ   (pend),
    .O_VALID (pend_valid),
    .O_IDX   (pend_idx)
  );

  assign live_vec = pend_valid ? int_vector(VECTOR_BASE, VECTOR_STRIDE, int'(pend_idx))
                               : 16'h0000;

  // Next-state logic. The ack clear only fires on the IDLE->SERVICE cycle,
  // and a hardware set is OR'd in last so it beats both a CPU write and an
  // ack clear of the same bit.
  always_comb begin
    state_d     = state_q;
    vec_latch_d = vec_latch_q;
    ack_clr     = '0;

    if (state_q == ST_IDLE) begin
      if (I_INT_ACK) begin
        vec_latch_d = live_vec;
        if (pend_valid) begin
          ack_clr[pend_idx] = 1'b1;
        end
        state_d = ST_SERVICE;
      end
    end else begin
      if (!I_INT_ACK) begin
        state_d = ST_IDLE;
      end
    end

    set_bits   = I_INT_SRC & ~src_prev_q;
    src_prev_d = I_INT_SRC;
    if_d       = ((if_we ? IO_DATA[NUM_SRC-1:0] : if_q) & ~ack_clr) | set_bits;
    ie_d       = ie_we ? IO_DATA : ie_q;
  end

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      if_q        <= '0;
      ie_q        <= 8'h00;
      src_prev_q  <= '0;
      state_q     <= ST_IDLE;
      vec_latch_q <= 16'h0000;
    end else begin
      if_q        <= if_d;
      ie_q        <= ie_d;
      src_prev_q  <= src_prev_d;
      state_q     <= state_d;
      vec_latch_q <= vec_latch_d;
    end
  end

  assign O_INT_PENDING = pend_valid;
  assign O_INT_VECTOR  = (state_q == ST_SERVICE) ? vec_latch_q : live_vec;
  assign O_IF_DATA     = if_rd_data;
  assign O_IE_DATA     = ie_q;

`ifdef INTC_WAKE_EN
  logic wake_q, wake_d;

  // Masking with ack_clr keeps the interrupt being acknowledged from waking
  assign wake_d = |(pend & ~ack_clr);

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      wake_q <= 1'b0;
    end else begin
      wake_q <= wake_d;
    end
  end

  assign O_WAKE = wake_q;
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed test-plan steps followed by a randomized phase, all checked
// against a behavioural model of IF/IE, the dispatch handshake and the
// vector table.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

  localparam logic [15:0] ADDR_IF    = 16'hFF0F;
  localparam logic [15:0] ADDR_IE    = 16'hFFFF;
  localparam logic [15:0] ADDR_OTHER = 16'hFF0E;

  localparam int OP_NOP      = 0;
  localparam int OP_WR_IF    = 1;
  localparam int OP_WR_IE    = 2;
  localparam int OP_RD_IF    = 3;
  localparam int OP_RD_IE    = 4;
  localparam int OP_WR_OTHER = 5;

  logic        I_CLOCK = 1'b0;
  logic        I_RESET;
  logic [15:0] I_ADDR;
  wire  [7:0]  IO_DATA;
  logic        I_RE_L;
  logic        I_WE_L;
  logic [4:0]  I_INT_SRC;
  logic        I_INT_ACK;
  logic        O_INT_PENDING;
  logic [15:0] O_INT_VECTOR;
  logic [7:0]  O_IF_DATA;
  logic [7:0]  O_IE_DATA;
`ifdef INTC_WAKE_EN
  logic        O_WAKE;
`endif

  logic [7:0]  tbData;
  logic        tbDrive;

  int passCount  = 0;
  int checkCount = 0;

  // Reference model state
  logic [4:0]  mIf;
  logic [7:0]  mIe;
  logic [4:0]  mPrev;
  logic        mInService;
  logic [15:0] mLatched;
  logic        mWake;

  assign IO_DATA = tbDrive ? tbData : 8'hzz;

  // Free-running clock
  always #5 I_CLOCK = ~I_CLOCK;

  interrupt_controller dut (
    .I_CLOCK       (I_CLOCK),
    .I_RESET       (I_RESET),
    .I_ADDR        (I_ADDR),
    .IO_DATA       (IO_DATA),
    .I_RE_L        (I_RE_L),
    .I_WE_L        (I_WE_L),
    .I_INT_SRC     (I_INT_SRC),
    .I_INT_ACK     (I_INT_ACK),
    .O_INT_PENDING (O_INT_PENDING),
    .O_INT_VECTOR  (O_INT_VECTOR),
    .O_IF_DATA     (O_IF_DATA),
    .O_IE_DATA     (O_IE_DATA)
`ifdef INTC_WAKE_EN
    ,
    .O_WAKE        (O_WAKE)
`endif
  );

  // Vector of the highest-priority (lowest) pending bit; 0 when none
  function automatic logic [15:0] refVector(input logic [4:0] pending);
    for (int i = 0; i < 5; i++) begin
      if (pending[i]) return 16'h0040 + 16'(8 * i);
    end
    return 16'h0000;
  endfunction

  function automatic logic [4:0] modelPend();
    return mIf & mIe[4:0];
  endfunction

  task automatic resetModel();
    mIf        = '0;
    mIe        = '0;
    mPrev      = '0;
    mInService = 1'b0;
    mLatched   = 16'h0000;
    mWake      = 1'b0;
  endtask

  // One clock of the reference behaviour, using the inputs held over the edge
  task automatic stepModel(input logic [4:0] src, input logic ack,
                           input int op, input logic [7:0] data);
    logic [4:0] pending;
    logic [4:0] clr;
    logic [4:0] base;
    pending = modelPend();
    clr     = '0;
    if (!mInService && ack) begin
      clr        = pending & (~pending + 5'd1);
      mLatched   = refVector(pending);
      mInService = 1'b1;
    end else if (mInService && !ack) begin
      mInService = 1'b0;
    end
    base  = (op == OP_WR_IF) ? data[4:0] : mIf;
    mWake = |(pending & ~clr);
    mIf   = (base & ~clr) | (src & ~mPrev);
    if (op == OP_WR_IE) mIe = data;
    mPrev = src;
  endtask

  task automatic checkValue(input string tag, input logic [15:0] observed,
                            input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Compare all visible outputs with the model
  task automatic checkOutput(input int op);
    checkValue("pending", {15'd0, O_INT_PENDING}, {15'd0, |modelPend()});
    checkValue("vector", O_INT_VECTOR, mInService ? mLatched : refVector(modelPend()));
    checkValue("if_dbg", {8'd0, O_IF_DATA}, {8'd0, 3'b111, mIf});
    checkValue("ie_dbg", {8'd0, O_IE_DATA}, {8'd0, mIe});
    if (op == OP_RD_IF) checkValue("if_read", {8'd0, IO_DATA}, {8'd0, 3'b111, mIf});
    if (op == OP_RD_IE) checkValue("ie_read", {8'd0, IO_DATA}, {8'd0, mIe});
`ifdef INTC_WAKE_EN
    checkValue("wake", {15'd0, O_WAKE}, {15'd0, mWake});
`endif
  endtask

  // Drive one cycle of inputs at posedge+1, check mid-cycle, then step the model
  task automatic applyStimulus(input logic rst, input logic [4:0] src, input logic ack,
                               input int op, input logic [7:0] data);
    I_RESET   = rst;
    I_INT_SRC = src;
    I_INT_ACK = ack;
    I_ADDR    = 16'h0000;
    I_RE_L    = 1'b1;
    I_WE_L    = 1'b1;
    tbDrive   = 1'b0;
    tbData    = data;
    case (op)
      OP_WR_IF:    begin I_ADDR = ADDR_IF;    I_WE_L = 1'b0; tbDrive = 1'b1; end
      OP_WR_IE:    begin I_ADDR = ADDR_IE;    I_WE_L = 1'b0; tbDrive = 1'b1; end
      OP_WR_OTHER: begin I_ADDR = ADDR_OTHER; I_WE_L = 1'b0; tbDrive = 1'b1; end
      OP_RD_IF:    begin I_ADDR = ADDR_IF;    I_RE_L = 1'b0; end
      OP_RD_IE:    begin I_ADDR = ADDR_IE;    I_RE_L = 1'b0; end
      default:     ;
    endcase
    if (rst) resetModel();
    #4;
    checkOutput(op);
    @(posedge I_CLOCK);
    if (rst) resetModel();
    else     stepModel(src, ack, op, data);
    #1;
  endtask

  // Directed test plan, then randomized traffic
  initial begin
    logic [4:0] rSrc;
    logic       rAck;
    int         rOp;

    I_RESET   = 1'b1;
    I_ADDR    = 16'h0000;
    I_RE_L    = 1'b1;
    I_WE_L    = 1'b1;
    I_INT_SRC = '0;
    I_INT_ACK = 1'b0;
    tbDrive   = 1'b0;
    tbData    = 8'h00;
    resetModel();
    @(posedge I_CLOCK);
    #1;

    // Reset state
    applyStimulus(1'b1, 5'b00000, 1'b0, OP_NOP, 8'h00);
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_RD_IF, 8'h00);
    checkValue("reset_vector", O_INT_VECTOR, 16'h0000);

    // Timer pulse with all sources enabled
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_WR_IE, 8'h1F);
    applyStimulus(1'b0, 5'b00100, 1'b0, OP_NOP, 8'h00);
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_RD_IF, 8'h00);
    checkValue("tp1_if", {8'd0, O_IF_DATA}, 16'h00E4);
    checkValue("tp1_pending", {15'd0, O_INT_PENDING}, 16'h0001);
    checkValue("tp1_vector", O_INT_VECTOR, 16'h0050);

    // Acknowledge handshake with IF=10101
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_WR_IF, 8'h15);
    applyStimulus(1'b0, 5'b00000, 1'b1, OP_NOP, 8'h00);
    checkValue("tp2_if_cleared", {8'd0, O_IF_DATA}, 16'h00F4);
    checkValue("tp2_vec_latched", O_INT_VECTOR, 16'h0040);
    applyStimulus(1'b0, 5'b00000, 1'b1, OP_NOP, 8'h00);
    checkValue("tp2_vec_held", O_INT_VECTOR, 16'h0040);
    checkValue("tp2_no_second_clear", {8'd0, O_IF_DATA}, 16'h00F4);
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_NOP, 8'h00);
    checkValue("tp2_vec_idle", O_INT_VECTOR, 16'h0050);

    // IE masking
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_WR_IE, 8'h00);
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_WR_IF, 8'h04);
    checkValue("tp3_masked", {15'd0, O_INT_PENDING}, 16'h0000);
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_WR_IE, 8'h04);
    checkValue("tp3_unmasked", {15'd0, O_INT_PENDING}, 16'h0001);
    checkValue("tp3_vector", O_INT_VECTOR, 16'h0050);

    // Hardware set beats a simultaneous CPU clear
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_WR_IE, 8'h1F);
    applyStimulus(1'b0, 5'b00001, 1'b0, OP_WR_IF, 8'h00);
    checkValue("tp4_set_wins", {8'd0, O_IF_DATA}, 16'h00E1);

    // Ack with nothing enabled
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_WR_IE, 8'h00);
    applyStimulus(1'b0, 5'b00000, 1'b1, OP_NOP, 8'h00);
    checkValue("tp5_null_vector", O_INT_VECTOR, 16'h0000);
    checkValue("tp5_if_kept", {8'd0, O_IF_DATA}, 16'h00E1);
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_NOP, 8'h00);
`ifdef INTC_WAKE_EN
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_WR_IE, 8'h01);
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_NOP, 8'h00);
    checkValue("tp5_wake", {15'd0, O_WAKE}, 16'h0001);
`endif

    // Level-held joypad sets IF only once
    applyStimulus(1'b0, 5'b00000, 1'b0, OP_WR_IF, 8'h00);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 5'b10000, 1'b0, (i == 5) ? OP_WR_IF : OP_NOP, 8'h00);
    end
    checkValue("tp6_no_retrigger", {8'd0, O_IF_DATA}, 16'h00E0);

    // Reset during SERVICE
    applyStimulus(1'b0, 5'b10000, 1'b0, OP_WR_IE, 8'h1F);
    applyStimulus(1'b0, 5'b10000, 1'b0, OP_WR_IF, 8'h02);
    applyStimulus(1'b0, 5'b10000, 1'b1, OP_NOP, 8'h00);
    checkValue("tp6_service_vec", O_INT_VECTOR, 16'h0048);
    I_RESET = 1'b1;
    #2;
    checkValue("tp6_reset_vector", O_INT_VECTOR, 16'h0000);
    checkValue("tp6_reset_pending", {15'd0, O_INT_PENDING}, 16'h0000);
    checkValue("tp6_reset_ie", {8'd0, O_IE_DATA}, 16'h0000);
    resetModel();
    @(posedge I_CLOCK);
    #1;
    applyStimulus(1'b1, 5'b10000, 1'b1, OP_NOP, 8'h00);
    applyStimulus(1'b0, 5'b10000, 1'b0, OP_RD_IF, 8'h00);
    applyStimulus(1'b0, 5'b10000, 1'b0, OP_RD_IF, 8'h00);
    checkValue("tp6_first_clock_set", {8'd0, O_IF_DATA}, 16'h00F0);

    // Randomized traffic
    rSrc = '0;
    rAck = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 3) == 0) rSrc[b] = ~rSrc[b];
      end
      if ($urandom_range(0, 2) == 0) rAck = ~rAck;
      rOp = int'($urandom_range(0, 9));
      if (rOp > OP_WR_OTHER) rOp = OP_NOP;
      applyStimulus(($urandom_range(0, 199) == 0), rSrc, rAck, rOp, 8'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects single-source interrupt requests, including the timer's one-cycle interrupt pulse, the VBlank, LCD STAT, serial and joypad requests, into the IF register (0xFF0F).
- Masks the pending requests with IE (0xFFFF) and presents a prioritised pending flag plus a dispatch vector to the CPU.
- Runs a request/acknowledge handshake that clears the serviced IF bit.
- Sits between the peripherals and the CPU core, on the same memory-mapped IO bus as the other IO registers.

Parameters:
- NUM_SRC, 5, number of interrupt sources. Bit 0 has the highest priority.
- VECTOR_BASE, 16'h0040, vector of source 0.
- VECTOR_STRIDE, 8, vector spacing between consecutive sources.

Ports:
- I_CLOCK  in  1  system clock, 2^23 Hz domain.
- I_RESET  in  1  reset, asynchronous, active-high.
- I_ADDR  in  16  bus address.
- IO_DATA  inout  8  bus data. Tristated unless this block is being read.
- I_RE_L  in  1  bus read enable, active-low.
- I_WE_L  in  1  bus write enable, active-low.
- I_INT_SRC  in  NUM_SRC  request lines. Bit order: 0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
- I_INT_ACK  in  1  CPU dispatch acknowledge. Level; held by the CPU until it has fetched the vector.
- O_INT_PENDING  out  1  |(IF & IE[NUM_SRC-1:0]).
- O_INT_VECTOR  out  16  dispatch address.
- O_IF_DATA  out  8  debug copy of IF as read.
- O_IE_DATA  out  8  debug copy of IE.

Behaviour:
- Reset values:
  - IF=0, IE=0, src_prev=0, state IDLE, vec_latch=16'h0000.
  - O_INT_PENDING=0, O_INT_VECTOR=16'h0000, IO_DATA=Z.
- Source edge detect:
  - set[i] = I_INT_SRC[i] & ~src_prev[i]. src_prev is registered every cycle.
  - A source already high when reset releases therefore sets its IF bit on the first clock.
  - Level-held sources set IF exactly once per rising edge.
- IF update, every clock: IF_next = ((IF_we ? IO_DATA[NUM_SRC-1:0] : IF) & ~ack_clr) | set.
  - Hardware set wins over both a CPU write and an ack clear of the same bit in the same cycle.
- IE: 8-bit register, written on IE_we. All 8 bits are stored and read back.
- Reads:
  - IF read returns {3'b111, IF}.
  - IE read returns IE.
  - Bus enables are decoded as (~I_RE_L & addr match) and (~I_WE_L & addr match), using the shared IF/IE address macros.
- Priority: the lowest-indexed set bit of (IF & IE[NUM_SRC-1:0]) wins. Its index is idx.
- Vector: VECTOR_BASE + VECTOR_STRIDE*idx, giving 0x40, 0x48, 0x50, 0x58, 0x60.
- FSM, two states:
  - IDLE:
    - O_INT_VECTOR is combinational from the current priority; 16'h0000 when nothing is pending.
    - On I_INT_ACK=1 with pending: latch the vector, assert ack_clr for bit idx for exactly this one cycle, go to SERVICE.
    - On I_INT_ACK=1 with nothing pending (request withdrawn by an IE/IF write before ack): latch 16'h0000, clear nothing, go to SERVICE.
  - SERVICE:
    - O_INT_VECTOR = vec_latch, held stable.
    - Further ack-level cycles clear nothing.
    - O_INT_PENDING continues to reflect live IF & IE.
    - Return to IDLE on the first cycle with I_INT_ACK=0.
- Latency:
  - Source edge to IF bit set: 1 clock.
  - IF set to O_INT_PENDING: combinational.
  - Ack to IF bit cleared: 1 clock.
- Reset mid-SERVICE: state forced to IDLE, all registers return to their reset values.

Optional Feature:
- Macro: INTC_WAKE_EN.
- Defined:
  - Adds output O_WAKE (1 bit), registered.
  - O_WAKE = |(IF & IE[NUM_SRC-1:0] & ~ack_clr), one cycle after the condition; the ack_clr term stops an interrupt just being acknowledged from raising wake.
  - Used to release CPU HALT/STOP independent of IME.
  - Reset value 0.
- Undefined: no O_WAKE port, no extra logic. The CPU derives wake from O_INT_PENDING.

Decomposition:
- Shared header alongside the existing memory definitions:
  - IF/IE address macros, if not already present.
  - Source index constants: INT_VBLANK=0, INT_STAT=1, INT_TIMER=2, INT_SERIAL=3, INT_JOYPAD=4.
  - Vector constants.
- Sub-module int_priority_enc: combinational NUM_SRC-bit lowest-set-bit encoder, outputs valid and idx.
- Edge detect, registers, FSM and tristates stay in the top module. Use the existing tristate and register primitives.

Test Plan:
- Reset, then write IE=8'h1F, then pulse I_INT_SRC[2] for 1 clock. Required: IF reads 8'hE4, O_INT_PENDING=1, O_INT_VECTOR=16'h0050.
- IF=5'b10101 with IE=8'h1F, then hold I_INT_ACK. Required:
  - Vector latches 0x0040; IF becomes 5'b10100 next clock.
  - Vector stays 0x0040 while ack is held.
  - Ack low returns to IDLE with vector 0x0050.
- IE=8'h00 with IF=8'h04. Required: O_INT_PENDING=0. Then write IE=8'h04: pending=1, vector 0x0050.
- Same cycle: CPU writes IF=8'h00 and I_INT_SRC[0] rises. Required: IF reads 8'hE1.
- Ack in IDLE with IF&IE=0. Required: vector 0x0000, no IF change. With INTC_WAKE_EN: IF=8'h01, IE=8'h01 gives O_WAKE=1 one clock later.
- Hold I_INT_SRC[4] high for 20 clocks, clear IF by write. Required: IF stays 8'hE0, no re-trigger. Assert I_RESET mid-SERVICE: vector 0x0000, state IDLE.
